// File: rtl/ccd_line_capture.sv
// ccd_line_capture: captures one CCD line via ADC handshake, buffers it, and locates the dark-line centre
module ccd_line_capture #(
  parameter int NPIX = 128,
  parameter int AW = 7,
  parameter int DW = 8,
  parameter int ADC_TIMEOUT = 16,
  parameter int MIN_CONTRAST = 32
) (
  input  logic          cam_clk,
  input  logic          rst,
  input  logic          cam_si,
  output logic          adc_start,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          line_valid,
  output logic          line_found,
  output logic [AW-1:0] line_pos,
  output logic [DW-1:0] line_thr,
  output logic [DW-1:0] pix_min,
  output logic [DW-1:0] pix_max,
  output logic          overrun,
  output logic          adc_err
);
  typedef enum logic [2:0] {IDLE, START, WAIT, ANALYSE, DONE} state_t;
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  state_t state, state_nx;
  logic [AW-1:0] idx, first_dark, last_dark, scan_pix;
  logic [AW:0] sidx;
  logic [TW-1:0] timer;
  logic [DW-1:0] run_min, run_max, scan_q, sample, thr;
  logic [DW-1:0] mem [NPIX];
  logic any_dark, timeout, adv, last_pix, scan_end, dark, found, finish;
  assign timeout = state == WAIT && timer == TW'(ADC_TIMEOUT - 1);
  assign adv = state == WAIT && !cam_si && (adc_done || timeout);
  assign sample = adc_done ? adc_data : '0;
  assign last_pix = idx == AW'(NPIX - 1);
  assign scan_end = sidx == (AW+1)'(NPIX);
  assign thr = DW'(({1'b0, run_min} + {1'b0, run_max}) >> 1);
  assign scan_pix = AW'(sidx - 1'b1);
  assign dark = state == ANALYSE && sidx != '0 && scan_q < thr;
  assign found = any_dark && (run_max - run_min >= DW'(MIN_CONTRAST));
  assign finish = state == DONE && !cam_si;
  always_ff @(posedge cam_clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = cam_si ? START :
               state == START ? WAIT :
               state == WAIT ? (adv ? (last_pix ? ANALYSE : START) : WAIT) :
               state == ANALYSE ? (scan_end ? DONE : ANALYSE) :
               IDLE;
  end
  always_comb begin
    adc_start = state == START;
    busy = state != IDLE;
  end
  always_ff @(posedge cam_clk) begin
    if (rst) begin
      idx <= '0;
      run_min <= '0;
      run_max <= '0;
      timer <= '0;
      sidx <= '0;
      any_dark <= 1'b0;
      first_dark <= '0;
      last_dark <= '0;
      line_valid <= 1'b0;
      line_found <= 1'b0;
      line_pos <= '0;
      line_thr <= '0;
      pix_min <= '0;
      pix_max <= '0;
      overrun <= 1'b0;
      adc_err <= 1'b0;
    end else begin
      if (cam_si) begin
        idx <= '0;
        run_min <= '1;
        run_max <= '0;
      end else if (adv) begin
        run_min <= sample < run_min ? sample : run_min;
        run_max <= sample > run_max ? sample : run_max;
        idx <= last_pix ? idx : idx + 1'b1;
      end
      timer <= state == WAIT ? timer + 1'b1 : '0;
      sidx <= state == ANALYSE ? sidx + 1'b1 : '0;
      if (state == START) any_dark <= 1'b0;
      else if (dark) begin
        any_dark <= 1'b1;
        last_dark <= scan_pix;
        if (!any_dark) first_dark <= scan_pix;
      end
      if (cam_si && state != IDLE) overrun <= 1'b1;
      if (adv && !adc_done) adc_err <= 1'b1;
      line_valid <= finish;
      if (finish) begin
        line_found <= found;
        line_pos <= found ? AW'(({1'b0, first_dark} + {1'b0, last_dark}) >> 1) : '0;
        line_thr <= thr;
        pix_min <= run_min;
        pix_max <= run_max;
      end
    end
  end
  always_ff @(posedge cam_clk) begin
    if (adv) mem[idx] <= sample;
    scan_q <= mem[sidx[AW-1:0]];
  end
  always_ff @(posedge cam_clk)
    rd_data <= rst ? '0 : ({1'b0, rd_addr} < (AW+1)'(NPIX) ? mem[rd_addr] : '0);
endmodule

// File: tb/tb_ccd_line_capture.sv
// tb_ccd_line_capture: directed scoreboard bench for ccd_line_capture
module tb_ccd_line_capture;
  localparam int NPIX = 128;
  localparam int ADC_TIMEOUT = 16;
  logic cam_clk = 1'b0;
  logic rst = 1'b1;
  logic cam_si = 1'b0;
  logic adc_start;
  logic adc_done = 1'b0;
  logic [7:0] adc_data = '0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic busy, line_valid, line_found, overrun, adc_err;
  logic [6:0] line_pos;
  logic [7:0] line_thr, pix_min, pix_max;
  typedef struct packed {
    logic       found;
    logic [6:0] pos;
    logic [7:0] thr;
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_t;
  exp_t q[$];
  logic [7:0] pix [NPIX];
  int n_tests = 0;
  int n_fail = 0;
  int n_pulse = 0;
  ccd_line_capture dut (
    .cam_clk(cam_clk), .rst(rst), .cam_si(cam_si), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .line_valid(line_valid), .line_found(line_found), .line_pos(line_pos),
    .line_thr(line_thr), .pix_min(pix_min), .pix_max(pix_max),
    .overrun(overrun), .adc_err(adc_err)
  );
  always #5 cam_clk = ~cam_clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic f, input int pos, input int thr, input int mn, input int mx);
    exp_t e;
    e.found = f;
    e.pos = 7'(pos);
    e.thr = 8'(thr);
    e.mn = 8'(mn);
    e.mx = 8'(mx);
    return e;
  endfunction
  always @(negedge cam_clk) begin
    exp_t e;
    if (line_valid === 1'b1) begin
      n_pulse++;
      if (q.size() == 0) check("unexpected_line_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("line_found", line_found, e.found);
        check("line_pos", line_pos, e.pos);
        check("line_thr", line_thr, e.thr);
        check("pix_min", pix_min, e.mn);
        check("pix_max", pix_max, e.mx);
      end
    end
  end
  task automatic tick;
    @(posedge cam_clk);
    #1;
  endtask
  task automatic start_line;
    cam_si = 1'b1;
    tick;
    cam_si = 1'b0;
  endtask
  task automatic wait_start;
    int n = 0;
    while (adc_start !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    if (adc_start !== 1'b1) check("adc_start_wait", 0, 1);
  endtask
  task automatic serve(input int lo, input int hi, input int wh);
    int n;
    for (int i = lo; i <= hi; i++) begin
      wait_start;
      if (i == wh) begin
        n = 1;
        tick;
        while (adc_start !== 1'b1 && n < 40) begin
          tick;
          n++;
        end
        check("timeout_cycles", n, ADC_TIMEOUT + 1);
      end else begin
        repeat (2) tick;
        adc_done = 1'b1;
        adc_data = pix[i];
        tick;
        adc_done = 1'b0;
      end
    end
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick;
      n++;
    end
    if (busy !== 1'b0) check("wait_idle", 1, 0);
    repeat (3) tick;
  endtask
  task automatic read_chk(input string name, input int a, input int exp);
    rd_addr = 7'(a);
    tick;
    check(name, rd_data, exp);
  endtask
  task automatic fill(input int kind);
    for (int i = 0; i < NPIX; i++)
      pix[i] = kind == 0 ? 8'(2 * i) : kind == 1 ? 8'd100 : ((i >= 40 && i <= 47) ? 8'd20 : 8'd200);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_adc_start", adc_start, 0);
    check("rst_line_found", line_found, 0);
    check("rst_line_pos", line_pos, 0);
    check("rst_line_thr", line_thr, 0);
    check("rst_pix_min", pix_min, 0);
    check("rst_pix_max", pix_max, 0);
    check("rst_overrun", overrun, 0);
    check("rst_adc_err", adc_err, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick;
    fill(0);
    q.push_back(mk(1, 31, 127, 0, 254));
    start_line;
    check("start_busy", busy, 1);
    serve(0, NPIX - 1, -1);
    wait_idle;
    read_chk("ramp_rd_100", 100, 200);
    fill(1);
    q.push_back(mk(0, 0, 100, 100, 100));
    start_line;
    serve(0, NPIX - 1, -1);
    wait_idle;
    fill(2);
    q.push_back(mk(1, 43, 110, 20, 200));
    start_line;
    serve(0, NPIX - 1, -1);
    wait_idle;
    read_chk("rd_45", 45, 20);
    read_chk("rd_0", 0, 200);
    read_chk("rd_47", 47, 20);
    read_chk("rd_48", 48, 200);
    fill(0);
    start_line;
    serve(0, 49, -1);
    wait_start;
    cam_si = 1'b1;
    tick;
    cam_si = 1'b0;
    check("overrun_set", overrun, 1);
    check("restart_adc_start", adc_start, 1);
    q.push_back(mk(1, 31, 127, 0, 254));
    serve(0, NPIX - 1, -1);
    wait_idle;
    check("overrun_sticky", overrun, 1);
    check("adc_err_clear", adc_err, 0);
    fill(1);
    q.push_back(mk(1, 10, 50, 0, 100));
    start_line;
    serve(0, NPIX - 1, 10);
    wait_idle;
    check("adc_err_set", adc_err, 1);
    read_chk("rd_timeout_px", 10, 0);
    read_chk("rd_11", 11, 100);
    fill(0);
    start_line;
    serve(0, NPIX - 1, -1);
    check("analyse_busy", busy, 1);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_line_valid", line_valid, 0);
    check("mid_rst_line_found", line_found, 0);
    check("mid_rst_line_pos", line_pos, 0);
    check("mid_rst_line_thr", line_thr, 0);
    check("mid_rst_pix_min", pix_min, 0);
    check("mid_rst_pix_max", pix_max, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_adc_err", adc_err, 0);
    repeat (NPIX + 5) tick;
    fill(2);
    q.push_back(mk(1, 43, 110, 20, 200));
    start_line;
    serve(0, NPIX - 1, -1);
    wait_idle;
    check("pulse_count", n_pulse, 6);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
